mips_multicycle_ctrl: RTL
=========================

# mips_multicycle_ctrl

Multicycle control unit for the MIPS datapath. It sequences instruction fetch, decode, execute, memory access and write-back through one Moore state machine. It drives every datapath enable and mux select: PC, IR, register file, ALU function code, data memory read/write. It also keeps retired-instruction and cycle counters for bring-up. It replaces the free-running state counter inside the datapath, and the datapath's control inputs are wired from this block.

## Interface
- `CNT_W`, default 32: width of `instr_count` and `cycle_count`.
- `clk`  in  1: single system clock; all state updates on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `opcode`  in  6: IR[31:26]; sampled only in DECODE.
- `funct`  in  6: IR[5:0]; sampled only in DECODE.
- `zero`  in  1: ALU zero flag; used only in EXEC_BR.
- `mem_ready`  in  1: data memory done; tie 1 for single-cycle memory.
- `stall`  in  1: freeze the FSM and counters while high.
- `pc_en`  out  1: PC load enable (already qualified by `zero` for beq).
- `pc_src`  out  2: 0 = PC+4, 1 = branch target, 2 = jump target.
- `ir_write`  out  1: latch instruction memory output into IR.
- `reg_write`  out  1: register file write enable.
- `reg_dst`  out  1: 1 = rd (IR[15:11]), 0 = rt.
- `mem_to_reg`  out  1: 1 = write-back from data memory, 0 = from ALU.
- `alu_src_b`  out  1: 1 = sign-extended immediate, 0 = rt data.
- `alu_func`  out  6: ALU function code, one of 32, 34, 36, 37, 42.
- `mem_read`, `mem_write`  out  1 each: data memory strobes.
- `illegal`  out  1: sticky; set when an unsupported opcode or funct is decoded.
- `state`  out  4: current state encoding, for debug.
- `instr_count`, `cycle_count`  out  CNT_W each.

## Operation
- Supported opcodes: R-type (0), lw (35), sw (43), beq (4), j (2), addi (8).
- Supported R-type functs: 32 add, 34 sub, 36 and, 37 or, 42 slt.
- States and transitions:
  - IDLE → FETCH.
  - FETCH → DECODE.
  - DECODE branches on opcode:
    - 0 → EXEC_R
    - 35/43 → EXEC_ADDR
    - 8 → EXEC_IMM
    - 4 → EXEC_BR
    - 2 → EXEC_J
    - anything else, or an unsupported funct with opcode 0 → TRAP
  - EXEC_R → WB_ALU.
  - EXEC_IMM → WB_ALU.
  - EXEC_ADDR → MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD → WB_MEM once `mem_ready` is high; otherwise stay.
  - MEM_WR → FETCH once `mem_ready` is high; otherwise stay.
  - EXEC_BR, EXEC_J, WB_ALU and WB_MEM → FETCH.
  - TRAP is absorbing until reset.
- Outputs are decoded from the registered state plus opcode/funct latched in DECODE. No output depends combinationally on `opcode`/`funct` inputs outside DECODE.
- Per-state assertions; every unlisted output is 0:
  - FETCH: `ir_write`=1, `pc_en`=1, `pc_src`=0.
  - EXEC_R: `alu_func` = latched funct.
  - EXEC_ADDR, EXEC_IMM: `alu_src_b`=1, `alu_func`=32.
  - EXEC_BR: `alu_func`=34, `pc_src`=1, `pc_en` = `zero`.
  - EXEC_J: `pc_en`=1, `pc_src`=2.
  - MEM_RD: `mem_read`=1, `alu_src_b`=1, `alu_func`=32.
  - MEM_WR: `mem_write`=1, `alu_src_b`=1, `alu_func`=32.
  - WB_ALU: `reg_write`=1; `reg_dst` = 1 for R-type, 0 for addi; `alu_func` held from the execute state.
  - WB_MEM: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0.
  - TRAP: `illegal`=1.
- In states where it is not listed, `alu_func` is 32.
- `instr_count` increments on every transition into FETCH from EXEC_BR, EXEC_J, MEM_WR, WB_ALU or WB_MEM.
- `cycle_count` increments on every cycle that is not in reset and not stalled.
- Both counters wrap modulo 2^CNT_W.

## Timing
- Reset values:
  - `state` = IDLE
  - all control outputs 0
  - `alu_func` = 32
  - `illegal` = 0
  - both counters 0
- Reset asserted mid-instruction aborts the instruction at once. No strobe survives into the reset cycle.
- First FETCH occurs on the second rising edge after reset deasserts.
- Instruction latency in cycles:
  - R-type, addi and sw: 4 (sw requires `mem_ready`=1).
  - lw: 5 (requires `mem_ready`=1).
  - beq and j: 3.
  - Each cycle with `mem_ready`=0 in MEM_RD/MEM_WR adds one cycle.
- `stall`:
  - Holds state, the latched opcode/funct and both counters.
  - Forces `pc_en`, `ir_write`, `reg_write` and `mem_write` to 0.
  - `mem_read` stays asserted if the FSM is in MEM_RD.
  - Stall takes priority over `mem_ready`.
- When `stall` and `mem_ready` rise together in MEM_RD, the FSM stays in MEM_RD. It advances on the first unstalled cycle that also has `mem_ready` high.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI.
  - funct constants F_ADD, F_SUB, F_AND, F_OR, F_SLT.
  - PC_SRC_* encodings.
  - the state enum typedef.
  - This package is shared with the ALU and the datapath.
- One natural sub-module: `mips_decode`. It is a combinational opcode/funct → next-execute-state and legality check. It is instantiated once and used only in DECODE.

## Test plan
- Reset, then `opcode`=0, `funct`=32 → states IDLE, FETCH, DECODE, EXEC_R, WB_ALU. `reg_write`=1 and `reg_dst`=1 in cycle 4 after FETCH. `instr_count`=1.
- lw (35) with `mem_ready` low for 2 cycles → MEM_RD held 3 cycles with `mem_read`=1. WB_MEM asserts `reg_write` and `mem_to_reg`. Total 7 cycles.
- beq (4): run once with `zero`=1 and once with `zero`=0 in EXEC_BR. `pc_en`=1 with `pc_src`=1 in the first case. `pc_en`=0 in the second. 3 cycles each.
- `opcode`=63, or `opcode`=0 with `funct`=0 → TRAP. `illegal`=1 persists for 20 cycles with no strobes until `rst` is pulsed.
- `stall` held 3 cycles during EXEC_ADDR of sw → state, counters and `mem_write` frozen at 0. MEM_WR follows one cycle after release.
- `rst` pulsed asynchronously mid-WB_ALU → `reg_write` drops before the next edge. State is IDLE and counters are 0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS multicycle controller, ALU and datapath.
// Holds opcode/funct constants, PC source encodings, the controller state enum,
// the control-word struct and the per-state control-word decode function.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_ADDI  = 6'd8;

    localparam logic [5:0] F_ADD = 6'd32;
    localparam logic [5:0] F_SUB = 6'd34;
    localparam logic [5:0] F_AND = 6'd36;
    localparam logic [5:0] F_OR  = 6'd37;
    localparam logic [5:0] F_SLT = 6'd42;

    localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StFetch    = 4'd1,
        StDecode   = 4'd2,
        StExecR    = 4'd3,
        StExecAddr = 4'd4,
        StExecImm  = 4'd5,
        StExecBr   = 4'd6,
        StExecJ    = 4'd7,
        StMemRd    = 4'd8,
        StMemWr    = 4'd9,
        StWbAlu    = 4'd10,
        StWbMem    = 4'd11,
        StTrap     = 4'd12
    } state_e;

    // pc_cond marks the beq state: the PC load is qualified by the live zero flag.
    typedef struct packed {
        logic       pc_en;
        logic       pc_cond;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_b;
        logic [5:0] alu_func;
        logic       mem_read;
        logic       mem_write;
        logic       illegal;
    } ctrl_t;

    // Control word for a state, given the opcode/funct latched in DECODE.
    function automatic ctrl_t ctrl_for_state(state_e st, logic [5:0] op, logic [5:0] fn);
        ctrl_t c;
        c          = '0;
        c.alu_func = F_ADD;
        case (st)
            StFetch: begin
                c.ir_write = 1'b1;
                c.pc_en    = 1'b1;
                c.pc_src   = PC_SRC_PLUS4;
            end
            StExecR: c.alu_func = fn;
            StExecAddr, StExecImm: c.alu_src_b = 1'b1;
            StExecBr: begin
                c.alu_func = F_SUB;
                c.pc_src   = PC_SRC_BRANCH;
                c.pc_cond  = 1'b1;
            end
            StExecJ: begin
                c.pc_en  = 1'b1;
                c.pc_src = PC_SRC_JUMP;
            end
            StMemRd: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 1'b1;
            end
            StMemWr: begin
                c.mem_write = 1'b1;
                c.alu_src_b = 1'b1;
            end
            StWbAlu: begin
                c.reg_write = 1'b1;
                c.reg_dst   = (op == OP_RTYPE);
                c.alu_func  = (op == OP_RTYPE) ? fn : F_ADD;
            end
            StWbMem: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            StTrap: c.illegal = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: controller <-> datapath bundle.
// Inputs to the controller: opcode, funct (IR fields), zero, mem_ready, stall.
// Outputs from the controller: PC/IR/regfile/memory enables, mux selects, alu_func, illegal.
// master = controller side, slave = datapath side.
interface mips_multicycle_ctrl_if;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       stall;

    logic       pc_en;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_b;
    logic [5:0] alu_func;
    logic       mem_read;
    logic       mem_write;
    logic       illegal;

    modport master (
        input  opcode, funct, zero, mem_ready, stall,
        output pc_en, pc_src, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_b,
               alu_func, mem_read, mem_write, illegal
    );

    modport slave (
        output opcode, funct, zero, mem_ready, stall,
        input  pc_en, pc_src, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_b,
               alu_func, mem_read, mem_write, illegal
    );

endinterface

// File: rtl/mips_decode.sv
// mips_decode: combinational opcode/funct decode.
// Ports: opcode, funct (in) -> exec_state (execute state to enter after DECODE),
//        legal (opcode, and funct for R-type, are supported).
import mips_pkg::*;

module mips_decode (
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output state_e     exec_state,
    output logic       legal
);

    always_comb begin
        exec_state = StTrap;
        legal      = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                exec_state = StExecR;
                case (funct)
                    F_ADD, F_SUB, F_AND, F_OR, F_SLT: legal = 1'b1;
                    default:                          legal = 1'b0;
                endcase
            end
            OP_LW, OP_SW: begin
                exec_state = StExecAddr;
                legal      = 1'b1;
            end
            OP_ADDI: begin
                exec_state = StExecImm;
                legal      = 1'b1;
            end
            OP_BEQ: begin
                exec_state = StExecBr;
                legal      = 1'b1;
            end
            OP_J: begin
                exec_state = StExecJ;
                legal      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore FSM sequencing fetch/decode/execute/memory/write-back
// for the multicycle MIPS datapath, plus retired-instruction and cycle counters.
// Ports: clk, rst (async, active-high); bus (master modport: IR fields, zero,
//        mem_ready, stall in; datapath controls out); state (debug encoding);
//        instr_count, cycle_count (CNT_W-bit, wrapping).
import mips_pkg::*;

module mips_multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    mips_multicycle_ctrl_if.master bus,
    output logic [3:0]            state,
    output logic [CNT_W-1:0]      instr_count,
    output logic [CNT_W-1:0]      cycle_count
);

    state_e           state_q, state_d;
    state_e           dec_state;
    logic             dec_legal;
    logic [5:0]       op_q, op_d;
    logic [5:0]       funct_q, funct_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

    mips_decode u_decode (
        .opcode     (bus.opcode),
        .funct      (bus.funct),
        .exec_state (dec_state),
        .legal      (dec_legal)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        funct_d     = funct_q;
        instr_cnt_d = instr_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        if (!bus.stall) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
            case (state_q)
                StIdle:   state_d = StFetch;
                StFetch:  state_d = StDecode;
                StDecode: begin
                    state_d = dec_legal ? dec_state : StTrap;
                    op_d    = bus.opcode;
                    funct_d = bus.funct;
                end
                StExecR, StExecImm: state_d = StWbAlu;
                StExecAddr: state_d = (op_q == OP_LW) ? StMemRd : StMemWr;
                StMemRd: if (bus.mem_ready) state_d = StWbMem;
                StMemWr: if (bus.mem_ready) state_d = StFetch;
                StExecBr, StExecJ, StWbAlu, StWbMem: state_d = StFetch;
                default: state_d = StTrap;
            endcase
            // Every entry to FETCH except the one out of IDLE retires an instruction.
            if (state_d == StFetch && state_q != StIdle) begin
                instr_cnt_d = instr_cnt_q + CNT_W'(1);
            end
        end
        // Control word is registered from the next state so outputs come straight off flops.
        ctrl_d = ctrl_for_state(state_d, op_d, funct_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= OP_RTYPE;
            funct_q     <= F_ADD;
            ctrl_q      <= ctrl_for_state(StIdle, OP_RTYPE, F_ADD);
            instr_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            funct_q     <= funct_d;
            ctrl_q      <= ctrl_d;
            instr_cnt_q <= instr_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    // Stall suppresses every state-changing strobe; mem_read is left alone so a
    // pending read keeps its request up.
    assign bus.pc_en      = (ctrl_q.pc_en | (ctrl_q.pc_cond & bus.zero)) & ~bus.stall;
    assign bus.ir_write   = ctrl_q.ir_write & ~bus.stall;
    assign bus.reg_write  = ctrl_q.reg_write & ~bus.stall;
    assign bus.mem_write  = ctrl_q.mem_write & ~bus.stall;
    assign bus.mem_read   = ctrl_q.mem_read;
    assign bus.pc_src     = ctrl_q.pc_src;
    assign bus.reg_dst    = ctrl_q.reg_dst;
    assign bus.mem_to_reg = ctrl_q.mem_to_reg;
    assign bus.alu_src_b  = ctrl_q.alu_src_b;
    assign bus.alu_func   = ctrl_q.alu_func;
    assign bus.illegal    = ctrl_q.illegal;

    assign state       = state_q;
    assign instr_count = instr_cnt_q;
    assign cycle_count = cycle_cnt_q;

endmodule
